// File: rtl/ultrasonic_scheduler.sv
// Ultrasonic ranging scheduler: fires one sensor trigger at a time, times
// the synchronized echo pulse into millimetres and publishes per-sensor
// distances through a small register bus (CTRL / STATUS / DIST0..3).
module ultrasonic_scheduler #(
    parameter int TRIG_CYC = 500,
    parameter int DIV_MM   = 290,
    parameter int MAX_MM   = 4000,
    parameter int WAIT_MAX = 50000,
    parameter int GAP_CYC  = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [3:0]  echo,
    output logic [3:0]  trig,
    output logic [15:0] d_out
);

    localparam int CMAX_A = (TRIG_CYC > WAIT_MAX) ? TRIG_CYC : WAIT_MAX;
    localparam int CMAX   = (CMAX_A > GAP_CYC) ? CMAX_A : GAP_CYC;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int PW     = $clog2(DIV_MM + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GAP
    } state_t;

    state_t           r_state;
    logic             r_run, r_os, r_tmo;
    logic [3:0]       r_mask, r_done, r_trig;
    logic [1:0]       r_cur;
    logic [3:0][15:0] r_dist;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_pre;
    logic [15:0]      r_mm, r_dout;
    logic [3:0]       r_sync1, r_sync2;

    logic             w_ctrl_wr, w_abort, w_rd, w_echo, w_pre_wrap;
    logic [3:0]       w_rd_clr;
    logic [2:0]       w_pick_run, w_pick_os0, w_pick_osn;
    logic             w_unused;

    // Returns {found, index}: lowest set mask bit at or after 'start';
    // with wrap the search continues past 3 back to 0.
    function automatic logic [2:0] f_pick(input logic [3:0] mask,
                                          input logic [2:0] start,
                                          input logic       wrap);
        logic [2:0] res;
        logic [2:0] j;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            j = start + 3'(i);
            if (wrap) j = {1'b0, j[1:0]};
            if (j <= 3'd3 && mask[j[1:0]]) res = {1'b1, j[1:0]};
        end
        return res;
    endfunction

    assign w_ctrl_wr  = cs && wr && (addr == 4'h0);
    assign w_abort    = w_ctrl_wr && (d_in[1:0] == 2'b00);
    assign w_rd       = cs && rd;
    assign w_rd_clr   = {w_rd && addr == 4'hA, w_rd && addr == 4'h8,
                         w_rd && addr == 4'h6, w_rd && addr == 4'h4};
    assign w_echo     = r_sync2[r_cur];
    assign w_pre_wrap = (r_pre == PW'(DIV_MM - 1));
    // Continuous run rotates past the current sensor; oneshot scans upward only.
    assign w_pick_run = f_pick(r_mask, {1'b0, r_cur} + 3'd1, 1'b1);
    assign w_pick_os0 = f_pick(r_mask, 3'd0, 1'b0);
    assign w_pick_osn = f_pick(r_mask, {1'b0, r_cur} + 3'd1, 1'b0);
    assign w_unused   = ^{d_in[15:8], d_in[3:2]};
    assign trig       = r_trig;
    assign d_out      = r_dout;

    // Two-flop synchronizer on every echo line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= echo;
            r_sync2 <= r_sync1;
        end
    end

    // Scheduler FSM, control register and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
            r_os    <= 1'b0;
            r_mask  <= '0;
            r_cur   <= '0;
            r_done  <= '0;
            r_tmo   <= 1'b0;
            r_dist  <= '0;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_mm    <= '0;
            r_trig  <= '0;
        end else begin
            // Read-clear first so a same-cycle new result overrides it.
            r_done <= r_done & ~w_rd_clr;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_trig  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_run && w_pick_run[2]) begin
                            r_state <= S_TRIG;
                            r_cur   <= w_pick_run[1:0];
                            r_trig  <= 4'b0001 << w_pick_run[1:0];
                            r_cnt   <= '0;
                        end else if (r_os && w_pick_os0[2]) begin
                            r_state <= S_TRIG;
                            r_cur   <= w_pick_os0[1:0];
                            r_trig  <= 4'b0001 << w_pick_os0[1:0];
                            r_cnt   <= '0;
                        end else begin
                            r_os <= 1'b0;
                        end
                    end
                    S_TRIG: begin
                        r_pre <= '0;
                        r_mm  <= '0;
                        if (r_cnt == CW'(TRIG_CYC - 1)) begin
                            r_trig  <= '0;
                            r_state <= S_WAIT_RISE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_WAIT_RISE: begin
                        if (w_echo) begin
                            // The rising cycle is the first counted echo cycle.
                            r_state <= S_MEASURE;
                            if (w_pre_wrap) begin
                                r_pre <= '0;
                                r_mm  <= r_mm + 16'd1;
                            end else begin
                                r_pre <= r_pre + 1'b1;
                            end
                        end else if (r_cnt == CW'(WAIT_MAX - 1)) begin
                            r_state        <= S_GAP;
                            r_dist[r_cur]  <= 16'hFFFF;
                            r_done[r_cur]  <= 1'b1;
                            r_tmo          <= 1'b1;
                            r_cnt          <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (!w_echo) begin
                            r_state       <= S_GAP;
                            r_dist[r_cur] <= r_mm;
                            r_done[r_cur] <= 1'b1;
                            r_tmo         <= 1'b0;
                            r_cnt         <= '0;
                        end else if (w_pre_wrap) begin
                            r_pre <= '0;
                            if (r_mm + 16'd1 >= 16'(MAX_MM)) begin
                                r_state       <= S_GAP;
                                r_dist[r_cur] <= 16'(MAX_MM);
                                r_done[r_cur] <= 1'b1;
                                r_tmo         <= 1'b0;
                                r_cnt         <= '0;
                            end else begin
                                r_mm <= r_mm + 16'd1;
                            end
                        end else begin
                            r_pre <= r_pre + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == CW'(GAP_CYC - 1)) begin
                            r_cnt <= '0;
                            if (r_run && w_pick_run[2]) begin
                                r_state <= S_TRIG;
                                r_cur   <= w_pick_run[1:0];
                                r_trig  <= 4'b0001 << w_pick_run[1:0];
                            end else if (!r_run && r_os && w_pick_osn[2]) begin
                                r_state <= S_TRIG;
                                r_cur   <= w_pick_osn[1:0];
                                r_trig  <= 4'b0001 << w_pick_osn[1:0];
                            end else begin
                                r_state <= S_IDLE;
                                r_os    <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            // Bus write comes last so a fresh oneshot is never lost.
            if (w_ctrl_wr) begin
                r_run  <= d_in[0];
                r_os   <= d_in[1];
                r_mask <= d_in[7:4];
            end
        end
    end

    // Registered read data; zero whenever no read is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd) begin
            case (addr)
                4'h2:    r_dout <= {8'b0, r_done, r_cur, r_tmo, r_state != S_IDLE};
                4'h4:    r_dout <= r_dist[0];
                4'h6:    r_dout <= r_dist[1];
                4'h8:    r_dout <= r_dist[2];
                4'hA:    r_dout <= r_dist[3];
                default: r_dout <= '0;
            endcase
        end else begin
            r_dout <= '0;
        end
    end

endmodule
